// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: T-state encoding, opcode values, IR field positions.
// Optional macro CU_MULDIV_EN adds mul/div to the opcode class decoder.
package cpu_pkg;

  localparam int NREGS_DEF = 16;
  localparam int OPW_DEF   = 5;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CL_BIN     = 3'd0,
    CL_UNARY   = 3'd1,
    CL_MULDIV  = 3'd2,
    CL_NOP     = 3'd3,
    CL_HALT    = 3'd4,
    CL_ILLEGAL = 3'd5
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:            c = CL_BIN;
      OP_NEG, OP_NOT:                           c = CL_UNARY;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                           c = CL_MULDIV;
`endif
      OP_NOP:                                   c = CL_NOP;
      OP_HALT:                                  c = CL_HALT;
      default:                                  c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sel_encode.sv
// Register select/encode: picks Ra/Rb/Rc, decodes it one-hot and gates it onto
// the register load or register drive vector.
module sel_encode
  import cpu_pkg::*;
#(
  parameter int NREGS = NREGS_DEF
) (
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [3:0]       rc,
  input  logic             gra,
  input  logic             grb,
  input  logic             grc,
  input  logic             rin,
  input  logic             rout,
  output logic [NREGS-1:0] R_enable,
  output logic [NREGS-1:0] R_out
);

  logic [3:0]       sel_s;
  logic [NREGS-1:0] dec_s;

  assign sel_s = ({4{gra}} & ra) | ({4{grb}} & rb) | ({4{grc}} & rc);

  always_comb begin
    dec_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      dec_s[i] = (sel_s == 4'(i));
    end
  end

  assign R_enable = rin  ? dec_s : '0;
  assign R_out    = rout ? dec_s : '0;

endmodule

// File: rtl/control_unit.sv
// Moore T-state sequencer for fetch and register-register ALU execution.
// Optional macro CU_MULDIV_EN adds the mul/div T5/T6 LO/HI sequence.
module control_unit
  import cpu_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             mem_rdy,
  input  logic             stop,
  output logic             PC_out,
  output logic             MAR_enable,
  output logic             IncPC,
  output logic             PC_enable,
  output logic             Read,
  output logic             MDR_enable,
  output logic             MDR_out,
  output logic             IR_enable,
  output logic             Y_enable,
  output logic             Z_enable,
  output logic             ZLow_out,
  output logic             ZHigh_out,
  output logic             HI_enable,
  output logic             LO_enable,
  output logic [NREGS-1:0] R_enable,
  output logic [NREGS-1:0] R_out,
  output logic [OPW-1:0]   opcode,
  output logic             run,
  output logic             illegal
);

  state_t    state_q, state_d, done_s;
  op_class_t cls_q, cls_d, cls_s, cls_e_s;
  logic      pend_q, pend_d;
  logic      illegal_q, illegal_d;
  logic      gra_s, grb_s, grc_s, rin_s, rout_s, op_en_s;
  logic      unused_ir_s;

  assign unused_ir_s = ^ir[RC_LSB-1:0];
  assign cls_s       = op_class(ir[OP_MSB:OP_LSB]);
  // The class is live from ir during T3 and held in cls_q for the rest of execute.
  assign cls_e_s     = (state_q == S_T3) ? cls_s : cls_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_RST;
      cls_q     <= CL_NOP;
      pend_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      pend_q    <= pend_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    pend_d    = pend_q | stop;
    illegal_d = illegal_q;
    done_s    = pend_d ? S_HALT : S_T0;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_rdy ? S_T2 : S_T1;
      S_T2:   state_d = S_T3;
      S_T3: begin
        cls_d = cls_s;
        case (cls_s)
          CL_BIN, CL_UNARY, CL_MULDIV: state_d = S_T4;
          CL_NOP:                      state_d = done_s;
          CL_HALT:                     state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_T4:   state_d = (cls_q == CL_UNARY) ? done_s : S_T5;
`ifdef CU_MULDIV_EN
      S_T5:   state_d = (cls_q == CL_MULDIV) ? S_T6 : done_s;
      S_T6:   state_d = done_s;
`else
      S_T5:   state_d = done_s;
`endif
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    PC_out = 1'b0; MAR_enable = 1'b0; IncPC = 1'b0; PC_enable = 1'b0;
    Read = 1'b0; MDR_enable = 1'b0; MDR_out = 1'b0; IR_enable = 1'b0;
    Y_enable = 1'b0; Z_enable = 1'b0; ZLow_out = 1'b0;
`ifdef CU_MULDIV_EN
    ZHigh_out = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0;
`endif
    gra_s = 1'b0; grb_s = 1'b0; grc_s = 1'b0;
    rin_s = 1'b0; rout_s = 1'b0; op_en_s = 1'b0;
    case (state_q)
      S_T0: begin
        PC_out = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; PC_enable = 1'b1;
      end
      S_T1: begin
        Read = 1'b1; MDR_enable = 1'b1;
      end
      S_T2: begin
        MDR_out = 1'b1; IR_enable = 1'b1;
      end
      S_T3: begin
        case (cls_e_s)
          CL_BIN:    begin rout_s = 1'b1; grb_s = 1'b1; Y_enable = 1'b1; end
          CL_UNARY:  begin rout_s = 1'b1; grb_s = 1'b1; op_en_s = 1'b1; Z_enable = 1'b1; end
          CL_MULDIV: begin rout_s = 1'b1; gra_s = 1'b1; Y_enable = 1'b1; end
          default:   begin rout_s = 1'b0; end
        endcase
      end
      S_T4: begin
        case (cls_e_s)
          CL_BIN:    begin rout_s = 1'b1; grc_s = 1'b1; op_en_s = 1'b1; Z_enable = 1'b1; end
          CL_UNARY:  begin ZLow_out = 1'b1; rin_s = 1'b1; gra_s = 1'b1; end
          CL_MULDIV: begin rout_s = 1'b1; grb_s = 1'b1; op_en_s = 1'b1; Z_enable = 1'b1; end
          default:   begin rout_s = 1'b0; end
        endcase
      end
      S_T5: begin
        case (cls_e_s)
          CL_BIN:    begin ZLow_out = 1'b1; rin_s = 1'b1; gra_s = 1'b1; end
`ifdef CU_MULDIV_EN
          CL_MULDIV: begin ZLow_out = 1'b1; LO_enable = 1'b1; end
`endif
          default:   begin rin_s = 1'b0; end
        endcase
      end
`ifdef CU_MULDIV_EN
      S_T6: begin
        ZHigh_out = 1'b1; HI_enable = 1'b1;
      end
`endif
      default: begin
        op_en_s = 1'b0;
      end
    endcase
  end

`ifndef CU_MULDIV_EN
  assign ZHigh_out = 1'b0;
  assign HI_enable = 1'b0;
  assign LO_enable = 1'b0;
`endif

  assign opcode  = op_en_s ? OPW'(ir[OP_MSB:OP_LSB]) : '0;
  assign run     = (state_q != S_RST) && (state_q != S_HALT);
  assign illegal = illegal_q;

  sel_encode #(.NREGS(NREGS)) u_sel (
    .ra       (ir[RA_MSB:RA_LSB]),
    .rb       (ir[RB_MSB:RB_LSB]),
    .rc       (ir[RC_MSB:RC_LSB]),
    .gra      (gra_s),
    .grb      (grb_s),
    .grc      (grc_s),
    .rin      (rin_s),
    .rout     (rout_s),
    .R_enable (R_enable),
    .R_out    (R_out)
  );

endmodule
